// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per step, holds it for decode, redirects on commit.
// Optional misaligned-target trap enabled by defining IFU_MISALIGN_TRAP_EN.
module ifu_fetch #(
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(64'h8000_0000),
    parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] inst_pc,
    input  logic            commit_valid,
    input  logic [2:0]      commit_branch,
    input  logic [XLEN-1:0] commit_target,
    output logic            fetch_fault
);

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_ISSUE, ST_EXEC, ST_FAULT
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_ISSUE, ST_EXEC
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] npc;
`ifdef IFU_MISALIGN_TRAP_EN
    logic            fault_q, fault_d;
`endif

    // Next-PC candidate selected by the commit branch code
    always_comb begin
        npc = commit_target;
        case (commit_branch)
            3'd0:    npc = pc_q + XLEN'(4);
            3'd2:    npc = commit_target & ~XLEN'(1);
            default: npc = commit_target;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ:   if (imem_req_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: if (inst_ready) state_d = ST_EXEC;
            ST_EXEC: begin
                if (commit_valid) begin
`ifdef IFU_MISALIGN_TRAP_EN
                    pc_d    = npc;
                    state_d = (npc[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
`else
                    pc_d    = npc & ~XLEN'(3);
                    state_d = ST_REQ;
`endif
                end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default:  state_d = ST_IDLE;
        endcase
        // Valids are registered off the next state so they align with it
        req_valid_d  = (state_d == ST_REQ);
        inst_valid_d = (state_d == ST_ISSUE);
`ifdef IFU_MISALIGN_TRAP_EN
        fault_d      = (state_d == ST_FAULT);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
`ifdef IFU_MISALIGN_TRAP_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = pc_q;
    assign opcode         = inst_q[6:0];
    assign func3          = inst_q[14:12];
    assign func7          = inst_q[31:25];
`ifdef IFU_MISALIGN_TRAP_EN
    assign fetch_fault    = fault_q;
`else
    assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized transaction-level bench for ifu_fetch; expected PC flow comes from a small arithmetic model.
module tb_ifu_fetch;
    localparam int unsigned XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req_valid, imem_req_ready;
    logic [63:0]     imem_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            inst_valid, inst_ready;
    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [63:0]     inst_pc;
    logic            commit_valid;
    logic [2:0]      commit_branch;
    logic [63:0]     commit_target;
    logic            fetch_fault;

    ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .opcode(opcode), .func3(func3), .func7(func7), .inst_pc(inst_pc),
        .commit_valid(commit_valid), .commit_branch(commit_branch), .commit_target(commit_target),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int unsigned     n_vec = 0;
    int unsigned     n_err = 0;
    longint unsigned cyc = 0;
    int unsigned     req_hs = 0;
    int unsigned     inst_hs = 0;
    logic [63:0]     exp_pc;

    always @(posedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) req_hs++;
        if (!rst && inst_valid && inst_ready) inst_hs++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [63:0] ref_npc(input logic [63:0] pc, input int br, input logic [63:0] tgt);
        if (br == 0) return pc + 64'd4;
        if (br == 2) return tgt & ~64'd1;
        return tgt;
    endfunction

    task automatic quiet_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        commit_valid    = 1'b0;
    endtask

    // One full instruction: request, response, issue, commit; called with the DUT in REQ
    task automatic run_inst(input logic [31:0] word, input int br, input logic [63:0] tgt,
                            input int rs, input int rd, input int is, input int ed,
                            output bit faulted);
        longint unsigned c0 = cyc;
        int unsigned     h0 = req_hs;
        int unsigned     i0 = inst_hs;
        logic [31:0]     prev = inst;
        logic [63:0]     npc;
        faulted = 1'b0;
        chk("req_valid", 64'(imem_req_valid), 64'd1);
        chk("imem_addr", imem_addr, exp_pc);
        chk("inst_pc_req", inst_pc, exp_pc);
        for (int k = 0; k < rs; k++) begin
            imem_req_ready  = 1'b0;
            commit_valid    = 1'($urandom_range(0, 1));
            commit_branch   = 3'($urandom);
            commit_target   = {$urandom, $urandom};
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            inst_ready      = 1'($urandom_range(0, 1));
            tick();
            chk("req_stall_valid", 64'(imem_req_valid), 64'd1);
            chk("req_stall_addr", imem_addr, exp_pc);
            chk("req_stall_inst", 64'(inst), 64'(prev));
        end
        quiet_inputs();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
        for (int k = 0; k < rd; k++) begin
            inst_ready   = 1'($urandom_range(0, 1));
            commit_valid = 1'($urandom_range(0, 1));
            tick();
            chk("wait_inst_valid", 64'(inst_valid), 64'd0);
            chk("wait_inst", 64'(inst), 64'(prev));
        end
        quiet_inputs();
        imem_resp_valid = 1'b1;
        imem_resp_data  = word;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        chk("issue_valid", 64'(inst_valid), 64'd1);
        chk("issue_inst", 64'(inst), 64'(word));
        chk("opcode", 64'(opcode), 64'(word[6:0]));
        chk("func3", 64'(func3), 64'(word[14:12]));
        chk("func7", 64'(func7), 64'(word[31:25]));
        chk("inst_pc", inst_pc, exp_pc);
        for (int k = 0; k < is; k++) begin
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            commit_valid    = 1'($urandom_range(0, 1));
            tick();
            chk("issue_stall_valid", 64'(inst_valid), 64'd1);
            chk("issue_stall_inst", 64'(inst), 64'(word));
            chk("issue_stall_pc", inst_pc, exp_pc);
        end
        quiet_inputs();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("exec_inst_valid", 64'(inst_valid), 64'd0);
        for (int k = 0; k < ed; k++) begin
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            imem_req_ready  = 1'($urandom_range(0, 1));
            inst_ready      = 1'($urandom_range(0, 1));
            tick();
            chk("exec_req_valid", 64'(imem_req_valid), 64'd0);
            chk("exec_inst", 64'(inst), 64'(word));
            chk("exec_pc", inst_pc, exp_pc);
        end
        quiet_inputs();
        commit_valid  = 1'b1;
        commit_branch = 3'(br);
        commit_target = tgt;
        tick();
        commit_valid = 1'b0;
        npc = ref_npc(exp_pc, br, tgt);
`ifdef IFU_MISALIGN_TRAP_EN
        if (npc[1:0] != 2'b00) begin
            exp_pc  = npc;
            faulted = 1'b1;
            chk("fault_set", 64'(fetch_fault), 64'd1);
            chk("fault_no_req", 64'(imem_req_valid), 64'd0);
            chk("fault_pc", inst_pc, npc);
            return;
        end
`else
        npc[1:0] = 2'b00;
`endif
        exp_pc = npc;
        chk("fetch_fault", 64'(fetch_fault), 64'd0);
        chk("next_req_valid", 64'(imem_req_valid), 64'd1);
        chk("next_addr", imem_addr, exp_pc);
        chk("latency", 64'(cyc - c0), 64'(4 + rs + rd + is + ed));
        chk("req_handshakes", 64'(req_hs - h0), 64'd1);
        chk("inst_handshakes", 64'(inst_hs - i0), 64'd1);
    endtask

    initial begin
        bit          f;
        logic [63:0] tgt;
        int          br;
        rst            = 1'b1;
        quiet_inputs();
        imem_resp_data = '0;
        commit_branch  = '0;
        commit_target  = '0;
        exp_pc         = RESET_PC;
        tick();
        tick();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'(NOP_INST));
        chk("rst_inst_pc", inst_pc, RESET_PC);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        rst = 1'b0;
        tick();
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_addr, RESET_PC);

        run_inst(32'h0010_0093, 0, 64'h0, 0, 0, 0, 0, f);
        chk("seq_addr", imem_addr, 64'h8000_0004);
        run_inst($urandom, 1, 64'h8000_0100, 0, 0, 0, 0, f);
        chk("jal_addr", imem_addr, 64'h8000_0100);
        run_inst($urandom, 2, 64'h8000_0201, 0, 0, 0, 0, f);
        chk("jalr_addr", imem_addr, 64'h8000_0200);
        run_inst($urandom, 0, 64'h0, 3, 0, 2, 0, f);
        run_inst($urandom, 5, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 1, f);
        run_inst($urandom, 0, 64'h0, 0, 0, 0, 0, f);
        chk("wrap_addr", imem_addr, 64'h0);

        for (int n = 0; n < 40; n++) begin
            br  = $urandom_range(0, 7);
            tgt = {$urandom, $urandom};
`ifdef IFU_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
            if (br == 2) tgt[0] = 1'($urandom);
`endif
            run_inst($urandom, br, tgt, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), f);
        end

        // Reset while a response is being offered in WAIT
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        rst             = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        tick();
        rst    = 1'b0;
        exp_pc = RESET_PC;
        chk("midrst_inst", 64'(inst), 64'(NOP_INST));
        chk("midrst_pc", inst_pc, RESET_PC);
        chk("midrst_inst_valid", 64'(inst_valid), 64'd0);
        tick();
        chk("midrst_req_valid", 64'(imem_req_valid), 64'd1);
        commit_valid  = 1'b1;
        commit_branch = 3'd1;
        commit_target = 64'h1234_5678;
        tick();
        tick();
        commit_valid = 1'b0;
        chk("spurious_commit_addr", imem_addr, RESET_PC);
        chk("spurious_commit_valid", 64'(imem_req_valid), 64'd1);

        run_inst($urandom, 1, 64'h8000_0102, 0, 0, 0, 0, f);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("misalign_faulted", 64'(f), 64'd1);
        imem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            imem_resp_valid = 1'($urandom_range(0, 1));
            commit_valid    = 1'($urandom_range(0, 1));
            inst_ready      = 1'($urandom_range(0, 1));
            tick();
            chk("fault_sticky", 64'(fetch_fault), 64'd1);
            chk("fault_req_valid", 64'(imem_req_valid), 64'd0);
            chk("fault_inst_valid", 64'(inst_valid), 64'd0);
        end
        quiet_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fault_cleared", 64'(fetch_fault), 64'd0);
`else
        chk("misalign_faulted", 64'(f), 64'd0);
        chk("misalign_addr", imem_addr, 64'h8000_0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
